// File: rtl/usb_cmd_responder.sv
// Single-byte command responder behind a USB-UART byte stream: ping, LED write/read, error status.
// Optional macro CMD_TIMEOUT_EN adds an argument-wait timeout in GET_ARG.
module usb_cmd_responder #(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd4800000,
  parameter logic [3:0]  LED_INIT       = 4'b0000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic [3:0] led,
  output logic       busy
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] GET_ARG = 2'd1;
  localparam logic [1:0] SEND    = 2'd2;

  localparam logic [7:0] OP_PING   = 8'h50;
  localparam logic [7:0] OP_READ   = 8'h52;
  localparam logic [7:0] OP_STATUS = 8'h53;
  localparam logic [7:0] OP_WRITE  = 8'h57;
  localparam logic [7:0] RPL_PONG  = 8'h4B;
  localparam logic [7:0] RPL_ACK   = 8'h06;
  localparam logic [7:0] RPL_NAK   = 8'h15;

  logic [1:0] state_reg;
  logic [7:0] tx_data_reg;
  logic       tx_valid_reg;
  logic [3:0] led_reg;
  logic [7:0] err_cnt_reg;
  logic [7:0] err_cnt_next;
  logic       rx_fire;
  logic       tx_fire;

`ifdef CMD_TIMEOUT_EN
  logic [23:0] timeout_cnt_reg;
`endif

  assign rx_ready = (state_reg != SEND);
  assign busy     = (state_reg != IDLE);
  assign tx_data  = tx_data_reg;
  assign tx_valid = tx_valid_reg;
  assign led      = led_reg;

  assign rx_fire = rx_valid && rx_ready;
  assign tx_fire = tx_valid_reg && tx_ready;

  // Error counter saturates so a flood of bad bytes never reads back as a small count.
  assign err_cnt_next = (err_cnt_reg == 8'hFF) ? 8'hFF : err_cnt_reg + 8'd1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      tx_data_reg  <= 8'h00;
      tx_valid_reg <= 1'b0;
      led_reg      <= LED_INIT;
      err_cnt_reg  <= 8'h00;
`ifdef CMD_TIMEOUT_EN
      timeout_cnt_reg <= 24'd0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (rx_fire) begin
            case (rx_data)
              OP_PING: begin
                tx_data_reg  <= RPL_PONG;
                tx_valid_reg <= 1'b1;
                state_reg    <= SEND;
              end
              OP_READ: begin
                tx_data_reg  <= {4'h0, led_reg};
                tx_valid_reg <= 1'b1;
                state_reg    <= SEND;
              end
              OP_STATUS: begin
                tx_data_reg  <= err_cnt_reg;
                tx_valid_reg <= 1'b1;
                state_reg    <= SEND;
              end
              OP_WRITE: begin
                state_reg <= GET_ARG;
`ifdef CMD_TIMEOUT_EN
                timeout_cnt_reg <= 24'd0;
`endif
              end
              default: begin
                tx_data_reg  <= RPL_NAK;
                tx_valid_reg <= 1'b1;
                err_cnt_reg  <= err_cnt_next;
                state_reg    <= SEND;
              end
            endcase
          end
        end
        GET_ARG: begin
          // An argument arriving on the expiry cycle takes priority over the timeout.
          if (rx_fire) begin
            led_reg      <= rx_data[3:0];
            tx_data_reg  <= RPL_ACK;
            tx_valid_reg <= 1'b1;
            state_reg    <= SEND;
          end
`ifdef CMD_TIMEOUT_EN
          else if (timeout_cnt_reg == TIMEOUT_CYCLES - 24'd1) begin
            tx_data_reg  <= RPL_NAK;
            tx_valid_reg <= 1'b1;
            err_cnt_reg  <= err_cnt_next;
            state_reg    <= SEND;
          end else begin
            timeout_cnt_reg <= timeout_cnt_reg + 24'd1;
          end
`endif
        end
        SEND: begin
          if (tx_fire) begin
            tx_valid_reg <= 1'b0;
            state_reg    <= IDLE;
          end
        end
        default: begin
          tx_valid_reg <= 1'b0;
          state_reg    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_usb_cmd_responder.sv
// Directed-vector bench for usb_cmd_responder; timeout scenario runs only when CMD_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_usb_cmd_responder;

  localparam logic [3:0] LED_RST = 4'h5;

  logic       clk;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [3:0] led;
  logic       busy;

  int compared;
  int mismatched;

  usb_cmd_responder #(
    .TIMEOUT_CYCLES(24'd16),
    .LED_INIT      (LED_RST)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .led     (led),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called at a negedge; returns 1 ns after the accepting posedge.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!rx_ready) begin
      compared++;
      mismatched++;
      $display("FAIL send_wait: rx_ready=%b required 1 for byte %02h", rx_ready, b);
    end
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  // Waits (bounded) for a reply, handshakes it, and returns at the following negedge.
  task automatic get_reply(output logic [7:0] d, output bit got);
    got = 1'b0;
    d   = 8'h00;
    tx_ready = 1'b1;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (tx_valid) got = 1'b1;
    end
    d = tx_data;
    @(posedge clk);
    #1;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    compared++;
    if (tx_valid !== 1'b0 || tx_data !== 8'h00 || led !== LED_RST || busy !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_state: tx_valid=%b tx_data=%02h led=%h busy=%b required 0 00 %h 0",
               tx_valid, tx_data, led, busy, LED_RST);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    compared++;
    if (rx_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL reset_rx_ready: rx_ready=%b required 1", rx_ready);
    end
    @(negedge clk);
    $display("reset: led=%h rx_ready=%b", led, rx_ready);
  endtask

  task automatic test_ping;
    tx_ready = 1'b1;
    send_byte(8'h50);
    @(negedge clk);
    compared++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h4B || rx_ready !== 1'b0 || busy !== 1'b1) begin
      mismatched++;
      $display("FAIL ping_reply: tx_valid=%b tx_data=%02h rx_ready=%b busy=%b required 1 4b 0 1",
               tx_valid, tx_data, rx_ready, busy);
    end
    @(negedge clk);
    compared++;
    if (tx_valid !== 1'b0 || busy !== 1'b0 || rx_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL ping_idle: tx_valid=%b busy=%b rx_ready=%b required 0 0 1", tx_valid, busy, rx_ready);
    end
    $display("ping: reply 4b checked");
  endtask

  task automatic test_write_read;
    logic [7:0] d;
    bit got;
    send_byte(8'h57);
    @(negedge clk);
    compared++;
    if (busy !== 1'b1 || rx_ready !== 1'b1 || tx_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL write_get_arg: busy=%b rx_ready=%b tx_valid=%b required 1 1 0", busy, rx_ready, tx_valid);
    end
    send_byte(8'h3A);
    @(negedge clk);
    compared++;
    if (led !== 4'hA || tx_valid !== 1'b1 || tx_data !== 8'h06) begin
      mismatched++;
      $display("FAIL write_ack: led=%h tx_valid=%b tx_data=%02h required a 1 06", led, tx_valid, tx_data);
    end
    @(negedge clk);
    send_byte(8'h52);
    get_reply(d, got);
    compared++;
    if (!got || d !== 8'h0A) begin
      mismatched++;
      $display("FAIL read_reply: got=%0d data=%02h required 1 0a", got, d);
    end
    $display("write/read: led=%h read=%02h", led, d);
  endtask

  task automatic test_rx_valid_low;
    logic [7:0] d;
    bit got;
    rx_data = 8'h50;
    rx_valid = 1'b0;
    repeat (4) @(negedge clk);
    compared++;
    if (tx_valid !== 1'b0 || busy !== 1'b0) begin
      mismatched++;
      $display("FAIL idle_ignore: tx_valid=%b busy=%b required 0 0", tx_valid, busy);
    end
    send_byte(8'h57);
    rx_data = 8'h0F;
    repeat (5) @(negedge clk);
    compared++;
    if (led !== 4'hA || tx_valid !== 1'b0 || busy !== 1'b1) begin
      mismatched++;
      $display("FAIL arg_ignore: led=%h tx_valid=%b busy=%b required a 0 1", led, tx_valid, busy);
    end
    send_byte(8'hC3);
    get_reply(d, got);
    compared++;
    if (!got || d !== 8'h06 || led !== 4'h3) begin
      mismatched++;
      $display("FAIL arg_high_nibble: got=%0d data=%02h led=%h required 1 06 3", got, d, led);
    end
    $display("rx_valid low ignored; arg c3 -> led=%h", led);
  endtask

  task automatic test_backpressure;
    bit bad;
    bad = 1'b0;
    tx_ready = 1'b0;
    send_byte(8'h50);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      compared++;
      if (tx_valid !== 1'b1 || tx_data !== 8'h4B || rx_ready !== 1'b0) begin
        mismatched++;
        $display("FAIL bp_hold[%0d]: tx_valid=%b tx_data=%02h rx_ready=%b required 1 4b 0",
                 i, tx_valid, tx_data, rx_ready);
      end
    end
    tx_ready = 1'b1;
    @(posedge clk);
    #1;
    tx_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (tx_valid !== 1'b0) bad = 1'b1;
    end
    compared++;
    if (bad) begin
      mismatched++;
      $display("FAIL bp_single_handshake: tx_valid re-asserted after handshake, required 0");
    end
    tx_ready = 1'b1;
    $display("backpressure: 10 held cycles, one handshake");
  endtask

  task automatic test_errors;
    logic [7:0] d;
    bit got;
    send_byte(8'h53);
    get_reply(d, got);
    compared++;
    if (!got || d !== 8'h00) begin
      mismatched++;
      $display("FAIL status_initial: got=%0d data=%02h required 1 00", got, d);
    end
    for (int i = 0; i < 300; i++) begin
      send_byte(8'h00);
      get_reply(d, got);
      compared++;
      if (!got || d !== 8'h15) begin
        mismatched++;
        $display("FAIL nak[%0d]: got=%0d data=%02h required 1 15", i, got, d);
      end
      if (i == 254) begin
        send_byte(8'h53);
        get_reply(d, got);
        compared++;
        if (!got || d !== 8'hFF) begin
          mismatched++;
          $display("FAIL status_255: got=%0d data=%02h required 1 ff", got, d);
        end
      end
    end
    send_byte(8'h53);
    get_reply(d, got);
    compared++;
    if (!got || d !== 8'hFF) begin
      mismatched++;
      $display("FAIL status_saturated: got=%0d data=%02h required 1 ff", got, d);
    end
    $display("errors: 300 naks, status=%02h", d);
  endtask

  task automatic test_reset_midop;
    logic [7:0] d;
    bit got;
    send_byte(8'h57);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    compared++;
    if (busy !== 1'b0 || rx_ready !== 1'b1 || tx_valid !== 1'b0 || led !== LED_RST) begin
      mismatched++;
      $display("FAIL reset_in_get_arg: busy=%b rx_ready=%b tx_valid=%b led=%h required 0 1 0 %h",
               busy, rx_ready, tx_valid, led, LED_RST);
    end
    send_byte(8'h52);
    get_reply(d, got);
    compared++;
    if (!got || d !== {4'h0, LED_RST}) begin
      mismatched++;
      $display("FAIL read_after_reset: got=%0d data=%02h required 1 %02h", got, d, {4'h0, LED_RST});
    end
    send_byte(8'h53);
    get_reply(d, got);
    compared++;
    if (!got || d !== 8'h00) begin
      mismatched++;
      $display("FAIL status_after_reset: got=%0d data=%02h required 1 00", got, d);
    end
    tx_ready = 1'b0;
    send_byte(8'h50);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    compared++;
    if (tx_valid !== 1'b0 || tx_data !== 8'h00 || busy !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_in_send: tx_valid=%b tx_data=%02h busy=%b required 0 00 0", tx_valid, tx_data, busy);
    end
    tx_ready = 1'b1;
    $display("reset mid-op: led=%h", led);
  endtask

`ifdef CMD_TIMEOUT_EN
  task automatic test_timeout;
    logic [7:0] d;
    bit got;
    bit early;
    early = 1'b0;
    send_byte(8'h57);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (tx_valid !== 1'b0) early = 1'b1;
    end
    @(negedge clk);
    compared++;
    if (early || tx_valid !== 1'b1 || tx_data !== 8'h15 || led !== LED_RST) begin
      mismatched++;
      $display("FAIL timeout_nak: early=%0d tx_valid=%b tx_data=%02h led=%h required 0 1 15 %h",
               early, tx_valid, tx_data, led, LED_RST);
    end
    @(negedge clk);
    send_byte(8'h53);
    get_reply(d, got);
    compared++;
    if (!got || d !== 8'h01) begin
      mismatched++;
      $display("FAIL timeout_err_cnt: got=%0d data=%02h required 1 01", got, d);
    end
    send_byte(8'h57);
    repeat (16) @(negedge clk);
    send_byte(8'h09);
    @(negedge clk);
    compared++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h06 || led !== 4'h9) begin
      mismatched++;
      $display("FAIL timeout_arg_wins: tx_valid=%b tx_data=%02h led=%h required 1 06 9", tx_valid, tx_data, led);
    end
    @(negedge clk);
    $display("timeout: nak after 16 cycles, coincident arg acked");
  endtask
`endif

  initial begin
    compared   = 0;
    mismatched = 0;
    rst_n      = 1'b0;
    rx_data    = 8'h00;
    rx_valid   = 1'b0;
    tx_ready   = 1'b1;
    @(negedge clk);
    test_reset;
    test_ping;
    test_write_read;
    test_rx_valid_low;
    test_backpressure;
    test_errors;
    test_reset_midop;
`ifdef CMD_TIMEOUT_EN
    test_timeout;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/usb_cmd_responder.md
USB_CMD_RESPONDER -- requirements
Module: usb_cmd_responder

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 24'd4800000, idle cycles allowed between a 'W' opcode and its argument byte.
REQ-002 SHALL have parameter LED_INIT, default 4'b0000, reset value of led.
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port rx_data  input  8  host-to-device byte (from usb_uart uart_out_data).
REQ-006 SHALL have port rx_valid  input  1  rx_data valid.
REQ-007 SHALL have port rx_ready  output  1  byte accepted when rx_valid && rx_ready.
REQ-008 SHALL have port tx_data  output  8  device-to-host reply byte (to usb_uart uart_in_data).
REQ-009 SHALL have port tx_valid  output  1  tx_data valid.
REQ-010 SHALL have port tx_ready  input  1  reply consumed when tx_valid && tx_ready.
REQ-011 SHALL have port led  output  4  registered LED output.
REQ-012 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, GET_ARG, SEND.
REQ-014 SHALL drive rx_ready = 1 in IDLE and GET_ARG and rx_ready = 0 in SEND, so at most one byte is in flight.
REQ-015 SHALL decode IDLE opcode bytes as follows:
- 0x50 'P': load reply 0x4B, go to SEND.
- 0x52 'R': load reply {4'h0, led}, go to SEND.
- 0x53 'S': load reply err_cnt, go to SEND.
- 0x57 'W': go to GET_ARG.
- any other byte: load reply 0x15 (NAK), increment err_cnt, go to SEND.
REQ-016 SHALL, on the byte accepted in GET_ARG, set led <= rx_data[3:0], load reply 0x06 (ACK) and go to SEND; rx_data[7:4] are ignored.
REQ-017 SHALL assert tx_valid the cycle after the accepting handshake (latency 1), with tx_data held stable until tx_valid && tx_ready.
REQ-018 SHALL hold tx_valid without dropping it while tx_ready is low.
REQ-019 SHALL, on the tx handshake cycle, deassert tx_valid and return to IDLE next cycle; the next opcode is accepted no earlier than the cycle after that.
REQ-020 SHALL keep err_cnt as 8 bits, saturating at 255 (no wrap).
REQ-021 SHALL make a 'W' update visible on led in the same cycle the ACK appears on tx_valid.
REQ-022 SHALL ignore rx_data when rx_valid is low, in every state.

Reset
REQ-023 SHALL, while rst_n is low at a clk edge, set the following, regardless of state, aborting any pending reply or argument wait:
- state = IDLE
- tx_valid = 0, tx_data = 0x00
- led = LED_INIT, err_cnt = 0, timeout counter = 0
REQ-024 SHALL drive rx_ready = 1 on the first cycle after rst_n returns high.

Configuration
REQ-025 SHALL, with macro CMD_TIMEOUT_EN defined, count cycles in GET_ARG with no accepted byte; when the count reaches TIMEOUT_CYCLES it SHALL load reply 0x15, increment err_cnt, leave led unchanged and go to SEND.
REQ-026 SHALL reset the timeout counter on entry to GET_ARG; if an argument byte and expiry coincide, the byte SHALL win.
REQ-027 SHALL, without CMD_TIMEOUT_EN, wait in GET_ARG indefinitely and contain no timeout counter logic.

Verification
REQ-028 Ping: send 0x50 with tx_ready=1 -> tx_valid high next cycle, tx_data=0x4B, back in IDLE 2 cycles after accept.
REQ-029 Write/read: send 0x57, 0x3A, then 0x52 -> replies 0x06 then 0x0A; led=4'hA.
REQ-030 Backpressure: send 0x50 with tx_ready=0 for 10 cycles -> tx_valid/tx_data=0x4B stable, rx_ready=0 throughout, then one handshake only.
REQ-031 Errors: send 0x00 300 times, then 0x53 -> 300 NAKs (0x15), status reply 0xFF (saturated).
REQ-032 Timeout (CMD_TIMEOUT_EN, TIMEOUT_CYCLES=16): send 0x57, no argument -> NAK after 16 idle cycles, led unchanged, err_cnt=1.
REQ-033 Reset mid-op: send 0x57, assert rst_n=0 one cycle -> IDLE, led=LED_INIT, tx_valid=0; next 0x52 replies {4'h0, LED_INIT}.
